// File: rtl/rf_pkg.sv
// Shared constants and command encoding for the 2-read/1-write register file.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  // Command bit positions inside read_or_write.
  localparam int RW_RD_BIT = 1;
  localparam int RW_WR_BIT = 0;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_WRITE = 2'b01,
    RW_READ  = 2'b10,
    RW_RDWR  = 2'b11
  } rw_cmd_e;

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: address mux with zero-forcing for reset, read-disable and R0.
// With RF_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module rf_read_port
  import rf_pkg::*;
(
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] regs [DEPTH],
`ifdef RF_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rd_data
);

  // NOTE: rd_data gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (rst && rd_en && (rd_addr != '0)) begin
`ifdef RF_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
      else                               rd_data = regs[rd_addr];
`else
      rd_data = regs[rd_addr];
`endif
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32 x 32-bit register file, two combinational read ports and one clocked write port; R0 reads 0.
// Define RF_BYPASS_EN to forward write_data to a read port reading the address being written.
module reg_file_2r1w
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        read_or_write,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              rd_en;
  logic              wr_en;

  assign rd_en = read_or_write[RW_RD_BIT];
  assign wr_en = read_or_write[RW_WR_BIT];

  // NOTE: the whole array is cleared by the asynchronous reset because software expects
  // every register to read 0 after reset; this keeps it in flops rather than a RAM macro.
  // Writes to R0 are dropped, so regs[0] never leaves 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en && (write_addr != '0)) begin
      regs[write_addr] <= write_data;
    end
  end

  rf_read_port u_rd_port_1 (
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (read_addr_1),
    .regs    (regs),
`ifdef RF_BYPASS_EN
    .wr_en   (wr_en),
    .wr_addr (write_addr),
    .wr_data (write_data),
`endif
    .rd_data (read_data_1)
  );

  rf_read_port u_rd_port_2 (
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (read_addr_2),
    .regs    (regs),
`ifdef RF_BYPASS_EN
    .wr_en   (wr_en),
    .wr_addr (write_addr),
    .wr_data (write_data),
`endif
    .rd_data (read_data_2)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: a reference model pushes expected read data to a
// scoreboard queue as stimulus is applied; entries are popped and compared against the ports.
module tb_reg_file_2r1w;
  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        rw;
  logic [ADDR_W-1:0] ra1, ra2, wa;
  logic [DATA_W-1:0] wd, rd1, rd2;

  always #5 clk = ~clk;

  reg_file_2r1w dut (
    .clk           (clk),
    .rst           (rst),
    .read_or_write (rw),
    .read_addr_1   (ra1),
    .read_addr_2   (ra2),
    .write_addr    (wa),
    .write_data    (wd),
    .read_data_1   (rd1),
    .read_data_2   (rd2)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } exp_t;

  logic [DATA_W-1:0] model [DEPTH];
  exp_t              sb [$];
  int                vectors     = 0;
  int                miscompares = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] ra);
    if (rst !== 1'b1 || rw[1] !== 1'b1 || ra == '0) return '0;
`ifdef RF_BYPASS_EN
    if (rw == 2'b11 && wa == ra) return wd;
`endif
    return model[ra];
  endfunction

  task automatic push_expect();
    exp_t e;
    e.d1 = model_read(ra1);
    e.d2 = model_read(ra2);
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, got %h/%h expected an entry", tag, rd1, rd2);
    end else begin
      e = sb.pop_front();
      check({tag, "/rd1"}, rd1, e.d1);
      check({tag, "/rd2"}, rd2, e.d2);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Drive one vector (called just after a falling edge), check before the rising edge and,
  // when clocked, again after the edge with the same inputs still applied.
  task automatic apply(input logic [1:0] rw_i, input logic [ADDR_W-1:0] ra1_i,
                       input logic [ADDR_W-1:0] ra2_i, input logic [ADDR_W-1:0] wa_i,
                       input logic [DATA_W-1:0] wd_i, input string tag, input bit clock);
    rw = rw_i; ra1 = ra1_i; ra2 = ra2_i; wa = wa_i; wd = wd_i;
    #1;
    push_expect();
    compare({tag, " pre"});
    if (clock) begin
      @(posedge clk);
      if (rst === 1'b1 && rw[0] && wa != '0) model[wa] = wd;
      #1;
      push_expect();
      compare({tag, " post"});
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rw = 2'b00; ra1 = '0; ra2 = '0; wa = '0; wd = '0;
    model_reset();
    #12;
    // Reset asserted with reads enabled: outputs forced to 0.
    rw = 2'b10; ra1 = 5'd1; ra2 = 5'd31;
    #1;
    check("reset rd1", rd1, '0);
    check("reset rd2", rd2, '0);
    @(negedge clk);
    rst = 1'b1;

    apply(2'b00, 5'd1, 5'd2, 5'd0, '0, "idle", 1'b0);
    apply(2'b10, 5'd1, 5'd2, 5'd0, '0, "read before write", 1'b0);

    apply(2'b01, 5'd1, 5'd1, 5'd1, 32'hF0F0_F0F0, "write r1 rd off", 1'b1);
    apply(2'b10, 5'd1, 5'd1, 5'd0, '0, "read r1", 1'b0);

    apply(2'b01, 5'd1, 5'd31, 5'd31, 32'h0F0F_0F0F, "write r31", 1'b1);
    apply(2'b10, 5'd1, 5'd31, 5'd0, '0, "read r31", 1'b0);

    apply(2'b11, 5'd0, 5'd0, 5'd0, 32'h0F0F_0F0F, "write r0", 1'b1);

    // Reset pulse clears everything, asynchronously and without a clock.
    rst = 1'b0;
    #1;
    check("async reset rd1", rd1, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++)
      apply(2'b10, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), 5'd0, '0, $sformatf("sweep %0d", a), 1'b0);

    apply(2'b11, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF, "rdwr same addr", 1'b1);
    apply(2'b11, 5'd5, 5'd9, 5'd9, 32'h1234_5678, "rdwr port2 hit", 1'b1);

    // Reset held across a write edge: the register stays 0.
    rst = 1'b0;
    model_reset();
    apply(2'b01, 5'd7, 5'd7, 5'd7, 32'hCAFE_F00D, "write in reset", 1'b1);
    rst = 1'b1;
    apply(2'b10, 5'd7, 5'd5, 5'd0, '0, "after reset write", 1'b0);

    for (int n = 0; n < 60; n++)
      apply(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom_range(0, 7)),
            $urandom, $sformatf("rand %0d", n), 1'b1);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
